serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/serial_sub_full_sub.sv | 22 ++
 rtl/serial_sub.sv | 106 ++++++++++
 tb/tb_serial_sub.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default operand width.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor assembled from two half-subtractor stages; the stage borrows are ORed.
module full_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_d1;
   logic w_b1;
   logic w_b2;

   // First stage a - b, second stage (a - b) - bin.
   assign w_d1 = a ^ b;
   assign w_b1 = ~a & b;
   assign w_b2 = ~w_d1 & bin;

   assign d    = w_d1 ^ bin;
   assign bout = w_b1 | w_b2;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one result bit per clock, LSB first, result published on FIN entry.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_bin;
   logic             r_busy;
   logic             r_done;
   logic             r_borrow;

   logic             w_d;
   logic             w_bout;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_res_nxt;

   full_sub u_full_sub (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .bin  (r_bin),
      .d    (w_d),
      .bout (w_bout)
   );

   assign w_accept  = start && (r_state == IDLE || r_state == FIN);
   assign w_last    = (r_cnt == LAST);
   assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = RUN;
         RUN:     if (w_last) w_state_nxt = FIN;
         FIN:     w_state_nxt = start ? RUN : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_diff   <= '0;
         r_cnt    <= '0;
         r_bin    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_borrow <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // busy/done are registered copies of the next state, keeping outputs glitch-free.
         r_busy  <= (w_state_nxt == RUN);
         r_done  <= (w_state_nxt == FIN);
         if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_res <= '0;
            r_bin <= 1'b0;
            r_cnt <= '0;
         end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res_nxt;
            r_bin <= w_bout;
            r_cnt <= r_cnt + CW'(1);
            // Visible result changes only on the final bit-cycle, so it holds steady through RUN.
            if (w_last) begin
               r_diff   <= w_res_nxt;
               r_borrow <= w_bout;
            end
         end
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign diff   = r_diff;
   assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and randomized bench for serial_sub at WIDTH=8 and WIDTH=4 against an arithmetic reference.
module tb_serial_sub;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s8, busy8, done8, borrow8;
   logic [7:0] a8, b8, diff8;
   logic       s4, busy4, done4, borrow4;
   logic [3:0] a4, b4, diff4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_sub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
   );

   serial_sub #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain unsigned arithmetic.
   function automatic int ref_diff(input int a, input int b, input int w);
      return (a - b) & ((1 << w) - 1);
   endfunction

   function automatic int ref_borrow(input int a, input int b);
      return (a < b) ? 1 : 0;
   endfunction

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input string tag);
      int cyc, busy_cnt, done_cyc;
      @(negedge clk);
      s8 = 1'b1; a8 = a; b8 = b;
      @(negedge clk);
      s8 = 1'b0;
      cyc = 1; busy_cnt = 0; done_cyc = -1;
      while (cyc <= 30) begin
         if (done8) begin
            done_cyc = cyc;
            break;
         end
         if (busy8) busy_cnt++;
         a8 = 8'($urandom); b8 = 8'($urandom);
         @(negedge clk);
         cyc++;
      end
      check($sformatf("%s latency", tag), 32'(done_cyc), 32'd9);
      check($sformatf("%s busy_cycles", tag), 32'(busy_cnt), 32'd8);
      check($sformatf("%s busy_in_fin", tag), 32'(busy8), 32'd0);
      check($sformatf("%s diff", tag), 32'(diff8), 32'(ref_diff(int'(a), int'(b), 8)));
      check($sformatf("%s borrow", tag), 32'(borrow8), 32'(ref_borrow(int'(a), int'(b))));
      @(negedge clk);
      check($sformatf("%s done_pulse_width", tag), 32'(done8), 32'd0);
      check($sformatf("%s diff_hold", tag), 32'(diff8), 32'(ref_diff(int'(a), int'(b), 8)));
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b);
      int cyc, done_cyc;
      @(negedge clk);
      s4 = 1'b1; a4 = a; b4 = b;
      @(negedge clk);
      s4 = 1'b0;
      cyc = 1; done_cyc = -1;
      while (cyc <= 20) begin
         if (done4) begin
            done_cyc = cyc;
            break;
         end
         a4 = 4'($urandom); b4 = 4'($urandom);
         @(negedge clk);
         cyc++;
      end
      check($sformatf("w4 %0h-%0h latency", a, b), 32'(done_cyc), 32'd5);
      check($sformatf("w4 %0h-%0h diff", a, b), 32'(diff4), 32'(ref_diff(int'(a), int'(b), 4)));
      check($sformatf("w4 %0h-%0h borrow", a, b), 32'(borrow4), 32'(ref_borrow(int'(a), int'(b))));
   endtask

   initial begin
      int cyc, pulses, d1, d2, held_bad;

      // Reset with start asserted: start must be ignored.
      rst_n = 1'b0;
      s8 = 1'b1; a8 = 8'h55; b8 = 8'h11;
      s4 = 1'b1; a4 = 4'h5; b4 = 4'h1;
      repeat (3) @(negedge clk);
      check("rst busy8", 32'(busy8), 32'd0);
      check("rst done8", 32'(done8), 32'd0);
      check("rst diff8", 32'(diff8), 32'd0);
      check("rst borrow8", 32'(borrow8), 32'd0);
      check("rst busy4", 32'(busy4), 32'd0);
      check("rst diff4", 32'(diff4), 32'd0);
      s8 = 1'b0; s4 = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst busy8", 32'(busy8), 32'd0);

      // Directed basic cases.
      op8(8'h05, 8'h03, "05-03");
      op8(8'h00, 8'h01, "00-01");
      op8(8'hFF, 8'hFF, "FF-FF");
      op8(8'h80, 8'h7F, "80-7F");
      op8(8'h00, 8'hFF, "00-FF");

      // Randomized operands.
      for (int i = 0; i < 20; i++) begin
         op8(8'($urandom), 8'($urandom), $sformatf("rand%0d", i));
      end

      // Start raised during the 3rd RUN cycle must be ignored.
      @(negedge clk);
      s8 = 1'b1; a8 = 8'h05; b8 = 8'h03;
      @(negedge clk);
      s8 = 1'b0;
      pulses = 0; d1 = -1;
      for (cyc = 1; cyc <= 25; cyc++) begin
         if (done8) begin
            pulses++;
            if (d1 < 0) d1 = cyc;
         end
         if (cyc == 3) begin
            s8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
         end else begin
            s8 = 1'b0;
         end
         @(negedge clk);
      end
      check("run_start latency", 32'(d1), 32'd9);
      check("run_start pulses", 32'(pulses), 32'd1);
      check("run_start diff", 32'(diff8), 32'h02);
      check("run_start borrow", 32'(borrow8), 32'd0);

      // Reset during the 4th RUN cycle aborts the operation.
      s8 = 1'b1; a8 = 8'h05; b8 = 8'h03;
      @(negedge clk);
      s8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort busy", 32'(busy8), 32'd0);
      check("abort done", 32'(done8), 32'd0);
      check("abort diff", 32'(diff8), 32'd0);
      check("abort borrow", 32'(borrow8), 32'd0);
      pulses = 0;
      repeat (20) begin
         @(negedge clk);
         if (done8) pulses++;
      end
      check("abort no_done", 32'(pulses), 32'd0);

      // Back-to-back: start in the FIN cycle, no idle gap.
      s8 = 1'b1; a8 = 8'h05; b8 = 8'h03;
      @(negedge clk);
      s8 = 1'b0;
      cyc = 1; d1 = -1;
      while (cyc <= 30) begin
         if (done8) begin
            d1 = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      check("b2b first latency", 32'(d1), 32'd9);
      check("b2b first diff", 32'(diff8), 32'h02);
      s8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
      @(negedge clk);
      cyc++;
      s8 = 1'b0;
      check("b2b no_gap busy", 32'(busy8), 32'd1);
      d2 = -1; held_bad = 0;
      while (cyc <= 60) begin
         if (done8) begin
            d2 = cyc;
            break;
         end
         if (diff8 !== 8'h02 || borrow8 !== 1'b0) held_bad++;
         a8 = 8'($urandom); b8 = 8'($urandom);
         @(negedge clk);
         cyc++;
      end
      check("b2b spacing", 32'(d2 - d1), 32'd9);
      check("b2b old_result_held", 32'(held_bad), 32'd0);
      check("b2b second diff", 32'(diff8), 32'hF0);
      check("b2b second borrow", 32'(borrow8), 32'd1);
      @(negedge clk);

      // WIDTH=4 exhaustive operand sweep.
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            op4(4'(ia), 4'(ib));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
